inst_itf_resp: RTL and testbench



---
 rtl/inst_itf_resp.sv | 129 ++++++++++++
 tb/tb_inst_itf_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_itf_resp.sv
// Instruction fetch responder: serves word fetches from a one-entry hit buffer
// or by a single read on the memory port, with range check and fetch timeout.
module inst_itf_resp #(
  parameter logic [31:0] BASE    = 32'h0000,
  parameter logic [31:0] END     = 32'h0fff,
  parameter int          AW      = 10,
  parameter int          TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inst_req_i,
  input  logic [31:0]   inst_addr_i,
  output logic          inst_ack_o,
  output logic [31:0]   inst_data_o,
  output logic          inst_error_o,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_err_i
);

  // A zero-width counter is not legal, so TIMEOUT=0 keeps one (unused) bit.
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
  localparam logic [31:0]   SPAN   = END - BASE;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          buf_valid_q;
  logic [29:0]   buf_tag_q;
  logic [31:0]   buf_data_q;
  logic [29:0]   tag_q;

  logic [31:0]   off;
  logic          in_range;
  logic          hit;
  logic [CW-1:0] cnt_inc;
  logic          to_hit;

  // Offset from BASE doubles as the range check: anything below BASE wraps
  // to a large value and fails the same compare as anything above END.
  assign off      = inst_addr_i - BASE;
  assign in_range = (off <= SPAN);
  assign hit      = buf_valid_q && (buf_tag_q == inst_addr_i[31:2]);
  assign cnt_inc  = cnt_q + 1'b1;
  assign to_hit   = (TIMEOUT != 0) && (cnt_inc == TO_LIM);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      inst_ack_o   <= 1'b0;
      inst_data_o  <= '0;
      inst_error_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
    end else begin
      inst_ack_o   <= 1'b0;
      inst_data_o  <= '0;
      inst_error_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inst_req_i) begin
            if (!in_range) begin
              state_q      <= RESP;
              inst_ack_o   <= 1'b1;
              inst_error_o <= 1'b1;
            end else if (hit) begin
              state_q     <= RESP;
              inst_ack_o  <= 1'b1;
              inst_data_o <= buf_data_q;
            end else begin
              state_q    <= REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= off[AW+1:2];
              tag_q      <= inst_addr_i[31:2];
              cnt_q      <= '0;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_inc;
          if (to_hit) begin
            mem_req_o    <= 1'b0;
            state_q      <= RESP;
            inst_ack_o   <= 1'b1;
            inst_error_o <= 1'b1;
          end else if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_inc;
          // Data arriving on the timeout cycle is still delivered.
          if (mem_rvalid_i) begin
            state_q      <= RESP;
            inst_ack_o   <= 1'b1;
            inst_data_o  <= mem_rdata_i;
            inst_error_o <= mem_err_i;
            if (!mem_err_i) begin
              buf_valid_q <= 1'b1;
              buf_tag_q   <= tag_q;
              buf_data_q  <= mem_rdata_i;
            end
          end else if (to_hit) begin
            state_q      <= RESP;
            inst_ack_o   <= 1'b1;
            inst_error_o <= 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Flush overrides a fill landing on the same edge.
      if (flush_i) buf_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_itf_resp.sv
// Directed bench for inst_itf_resp: miss, hit, range, timeout, flush, reset.
module tb_inst_itf_resp;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          inst_req_i;
  logic [31:0]   inst_addr_i;
  logic          inst_ack_o;
  logic [31:0]   inst_data_o;
  logic          inst_error_o;
  logic          flush_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_err_i;

  int n_chk = 0;
  int n_err = 0;

  inst_itf_resp #(.BASE(32'h0000), .END(32'h0fff), .AW(AW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_ack_o(inst_ack_o), .inst_data_o(inst_data_o), .inst_error_o(inst_error_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_ack(input string tag, input logic a, input logic [31:0] d, input logic e);
    chk({tag, ".ack"}, 32'(inst_ack_o), 32'(a));
    chk({tag, ".data"}, inst_data_o, d);
    chk({tag, ".err"}, 32'(inst_error_o), 32'(e));
  endtask

  initial begin
    int bad;
    rst_ni = 1'b0; inst_req_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    tick(); tick();
    chk_ack("rst", 1'b0, 32'h0, 1'b0);
    chk("rst.mreq", 32'(mem_req_o), 32'h0);
    chk("rst.maddr", 32'(mem_addr_o), 32'h0);
    rst_ni = 1'b1;

    // stray rvalid while idle produces nothing
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    tick();
    chk("stray.ack", 32'(inst_ack_o), 32'h0);
    mem_rvalid_i = 1'b0;

    // miss 0x104: grant after 2 cycles, rvalid 3 cycles later
    inst_req_i = 1'b1; inst_addr_i = 32'h104;
    tick();
    chk("miss.mreq", 32'(mem_req_o), 32'h1);
    chk("miss.maddr", 32'(mem_addr_o), 32'h41);
    chk("miss.ack0", 32'(inst_ack_o), 32'h0);
    tick();
    chk("miss.hold", 32'(mem_req_o), 32'h1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("miss.mreq_drop", 32'(mem_req_o), 32'h0);
    tick(); tick();
    chk("miss.noack", 32'(inst_ack_o), 32'h0);
    chk("miss.nodata", inst_data_o, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0; inst_req_i = 1'b0;
    chk_ack("miss.resp", 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk_ack("miss.pulse", 1'b0, 32'h0, 1'b0);

    // hit 0x106 (same word)
    inst_req_i = 1'b1; inst_addr_i = 32'h106;
    tick();
    inst_req_i = 1'b0;
    chk_ack("hit", 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("hit.mreq", 32'(mem_req_o), 32'h0);
    tick();
    chk("hit.pulse", 32'(inst_ack_o), 32'h0);

    // out of range: 0x2000 and just past END
    inst_req_i = 1'b1; inst_addr_i = 32'h2000;
    tick();
    inst_req_i = 1'b0;
    chk_ack("oor", 1'b1, 32'h0, 1'b1);
    chk("oor.mreq", 32'(mem_req_o), 32'h0);
    tick();
    inst_req_i = 1'b1; inst_addr_i = 32'h1000;
    tick();
    inst_req_i = 1'b0;
    chk_ack("oor_end", 1'b1, 32'h0, 1'b1);
    tick();

    // last word in range, memory returns an error: not buffered
    inst_req_i = 1'b1; inst_addr_i = 32'hFFF; mem_gnt_i = 1'b1;
    tick();
    chk("top.maddr", 32'(mem_addr_o), 32'h3FF);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hA5A5_0001;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; inst_req_i = 1'b0;
    chk_ack("rerr", 1'b1, 32'hA5A5_0001, 1'b1);
    tick();
    inst_req_i = 1'b1; inst_addr_i = 32'hFFC;
    tick();
    chk("rerr.refetch", 32'(mem_req_o), 32'h1);
    chk("rerr.noack", 32'(inst_ack_o), 32'h0);
    rst_ni = 1'b0; inst_req_i = 1'b0;
    tick();
    chk("rst_req.mreq", 32'(mem_req_o), 32'h0);
    rst_ni = 1'b1;

    // 0x104 is no longer buffered after reset; refill it before the timeout test
    inst_req_i = 1'b1; inst_addr_i = 32'h104; mem_gnt_i = 1'b1;
    tick();
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0; inst_req_i = 1'b0;
    chk_ack("refill", 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();

    // timeout: granted at once, rvalid never; error ack after 16 cycles
    inst_req_i = 1'b1; inst_addr_i = 32'h300;
    tick();
    chk("to.mreq", 32'(mem_req_o), 32'h1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (inst_ack_o !== 1'b0) bad++;
    end
    chk("to.early_ack", 32'(bad), 32'h0);
    tick();
    inst_req_i = 1'b0;
    chk_ack("to.resp", 1'b1, 32'h0, 1'b1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    chk("to.late", 32'(inst_ack_o), 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    chk("to.late2", 32'(inst_ack_o), 32'h0);
    inst_req_i = 1'b1; inst_addr_i = 32'h104;
    tick();
    inst_req_i = 1'b0;
    chk_ack("to.bufkeep", 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();

    // flush with the fill of 0x200; req dropped before ack still completes
    inst_req_i = 1'b1; inst_addr_i = 32'h200;
    tick();
    inst_req_i = 1'b0;
    chk("fl.maddr", 32'(mem_addr_o), 32'h80);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D; flush_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0; flush_i = 1'b0;
    chk_ack("fl.resp", 1'b1, 32'hCAFE_F00D, 1'b0);
    tick();
    inst_req_i = 1'b1; inst_addr_i = 32'h200;
    tick();
    chk("fl.miss", 32'(mem_req_o), 32'h1);
    chk("fl.noack", 32'(inst_ack_o), 32'h0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    tick();
    mem_rvalid_i = 1'b0; inst_req_i = 1'b0;
    chk_ack("fl.refill", 1'b1, 32'h1111_2222, 1'b0);
    tick();

    // reset in WAIT abandons the fetch and clears the buffer
    inst_req_i = 1'b1; inst_addr_i = 32'h400;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; rst_ni = 1'b0; inst_req_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk_ack("rw", 1'b0, 32'h0, 1'b0);
    chk("rw.mreq", 32'(mem_req_o), 32'h0);
    chk("rw.maddr", 32'(mem_addr_o), 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    tick();
    mem_rvalid_i = 1'b0;
    chk("rw.noack", 32'(inst_ack_o), 32'h0);
    inst_req_i = 1'b1; inst_addr_i = 32'h200;
    tick();
    inst_req_i = 1'b0;
    chk("rw.miss", 32'(mem_req_o), 32'h1);
    chk("rw.miss_ack", 32'(inst_ack_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
